keypad_scan_ctrl: RTL and testbench

Owns the SWORD 5x5 button matrix and turns it into debounced key events. It drives the column-select lines and samples the row lines after a settle time. A 25-bit frame is built each scan; a change is accepted only after the frame has been stable for several consecutive scans. Each accepted bit change is pushed as a press/release event code into a small FIFO that the MIPSfpga bus peripheral pops with a valid/ready handshake.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/keypad_evt_fifo.sv | 45 ++++
 rtl/keypad_scan_ctrl.sv | 143 ++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, FSM state encoding and the column-drive helper for the 5x5 keypad scanner.
package keypad_pkg;
  localparam int NUM_ROWS      = 5;
  localparam int NUM_COLS      = 5;
  localparam int NUM_KEYS      = 25;
  localparam int KEY_IDX_W     = 5;
  localparam int EVT_W         = 6;
  localparam int EVT_PRESS_BIT = 5;

  typedef enum logic [1:0] {
    SCAN = 2'd0,
    EVAL = 2'd1,
    EMIT = 2'd2
  } state_t;

  function automatic logic [NUM_COLS-1:0] col_drive(input logic [2:0] col);
    return ~(NUM_COLS'(1) << col);
  endfunction
endpackage

// File: rtl/keypad_evt_fifo.sv
// Synchronous first-word-fall-through event FIFO: dout shows the head with no read latency.
// A push while full is refused unless a pop frees the head slot in the same cycle.
module keypad_evt_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_push;
  logic             w_do_pop;

  // Extra MSB on each pointer distinguishes full from empty when the indices match.
  assign empty     = (r_wr == r_rd);
  assign full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);
  assign dout      = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + PTR_ONE;
      if (w_do_pop)  r_rd <= r_rd + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// Scans the 5x5 button matrix, debounces whole frames and queues press/release events.
// Frame = 5*SETTLE_CYC+1 cycles (+25 when emitting); full FIFO with no pop drops events and sets overflow.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYC     = 16,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_ROWS-1:0] btny,
  output logic [NUM_COLS-1:0] btnx,
  output logic                key_valid,
  output logic [EVT_W-1:0]    key_code,
  input  logic                key_ready,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                overflow,
  input  logic                clr_ovf
);
  localparam int CNT_W = $clog2(SETTLE_CYC);
  localparam int STB_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_SCANS);

  state_t               r_state;
  logic [2:0]           r_col;
  logic [CNT_W-1:0]     r_cnt;
  logic [KEY_IDX_W-1:0] r_idx;
  logic [NUM_KEYS-1:0]  r_frame;
  logic [NUM_KEYS-1:0]  r_prev;
  logic [NUM_KEYS-1:0]  r_key_state;
  logic [STB_W-1:0]     r_stable;
  logic [NUM_COLS-1:0]  r_btnx;
  logic                 r_ovf;

  logic [STB_W-1:0] w_stable_nxt;
  logic [EVT_W-1:0] w_evt;
  logic [EVT_W-1:0] w_head;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;

  always_comb begin
    w_stable_nxt = STB_W'(1);
    if (r_frame == r_prev)
      w_stable_nxt = (r_stable >= STB_MAX) ? STB_MAX : r_stable + STB_W'(1);
  end

  always_comb begin
    w_evt                  = '0;
    w_evt[EVT_PRESS_BIT]   = r_frame[r_idx];
    w_evt[KEY_IDX_W-1:0]   = r_idx;
  end

  assign w_push = (r_state == EMIT) && (r_frame[r_idx] != r_key_state[r_idx]);
  assign w_drop = w_push && w_full && !key_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SCAN;
      r_col       <= '0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_frame     <= '0;
      r_prev      <= '0;
      r_key_state <= '0;
      r_stable    <= '0;
      r_btnx      <= '1;
    end else begin
      case (r_state)
        SCAN: begin
          // Out of reset no column is driven yet: drive column 0 before counting its settle time.
          if (r_btnx == '1) begin
            r_btnx <= col_drive(r_col);
          end else if (r_cnt == CNT_LAST) begin
            r_frame[r_col*NUM_ROWS +: NUM_ROWS] <= ~btny;
            r_cnt <= '0;
            if (r_col == 3'(NUM_COLS - 1)) begin
              r_state <= EVAL;
              r_btnx  <= '1;
            end else begin
              r_col  <= r_col + 3'd1;
              r_btnx <= col_drive(r_col + 3'd1);
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        EVAL: begin
          r_stable <= w_stable_nxt;
          r_prev   <= r_frame;
          r_col    <= '0;
          if ((w_stable_nxt >= STB_MAX) && (r_frame != r_key_state)) begin
            r_state <= EMIT;
            r_idx   <= '0;
          end else begin
            r_state <= SCAN;
            r_btnx  <= col_drive(3'd0);
          end
        end
        EMIT: begin
          // key_state follows the frame even if the FIFO drops the event.
          if (w_push) r_key_state[r_idx] <= r_frame[r_idx];
          if (r_idx == KEY_IDX_W'(NUM_KEYS - 1)) begin
            r_state <= SCAN;
            r_btnx  <= col_drive(3'd0);
          end else begin
            r_idx <= r_idx + KEY_IDX_W'(1);
          end
        end
        default: r_state <= SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst)          r_ovf <= 1'b0;
    else if (w_drop)  r_ovf <= 1'b1;
    else if (clr_ovf) r_ovf <= 1'b0;
  end

  keypad_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_evt),
    .pop   (key_ready),
    .dout  (w_head),
    .empty (w_empty),
    .full  (w_full)
  );

  assign btnx      = r_btnx;
  assign key_valid = !w_empty;
  assign key_code  = w_empty ? '0 : w_head;
  assign key_state = r_key_state;
  assign overflow  = r_ovf;
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: matrix model, frame-schedule reference model with per-cycle compare, directed scenarios.
module tb_keypad_scan_ctrl;
  localparam int S     = 4;
  localparam int DB    = 2;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  btny;
  logic [4:0]  btnx;
  logic        key_valid;
  logic [5:0]  key_code;
  logic        key_ready;
  logic [24:0] key_state;
  logic        overflow;
  logic        clr_ovf;
  logic [24:0] held;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SETTLE_CYC     (S),
    .DEBOUNCE_SCANS (DB),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btny      (btny),
    .btnx      (btnx),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .key_state (key_state),
    .overflow  (overflow),
    .clr_ovf   (clr_ovf)
  );

  // Physical matrix: a held key pulls its row low while its column is driven.
  always_comb begin
    btny = 5'h1F;
    for (int c = 0; c < 5; c++)
      if (btnx[c] == 1'b0)
        for (int r = 0; r < 5; r++)
          if (held[c*5 + r]) btny[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: time position within the frame schedule, frames, queue of events.
  bit          m_on = 1'b0;
  bit          m_load;
  bit          m_emit;
  int          m_pos;
  int          m_stable;
  int          m_i;
  logic [24:0] m_frame, m_prev, m_ks;
  logic [5:0]  m_q[$];
  logic        m_ovf;
  bit          mp_pop, mp_push, mp_drop;
  logic [5:0]  mp_ev;
  logic [4:0]  m_eb;

  always @(posedge clk) begin
    if (rst) begin
      m_on = 1'b1; m_load = 1'b1; m_pos = 0; m_emit = 1'b0; m_stable = 0;
      m_frame = '0; m_prev = '0; m_ks = '0; m_ovf = 1'b0;
      m_q.delete();
    end else if (m_on) begin
      mp_pop  = key_ready && (m_q.size() > 0);
      mp_push = 1'b0;
      mp_ev   = '0;
      if (m_load) begin
        m_load = 1'b0;
        m_pos  = 0;
      end else begin
        if (m_pos < 5*S) begin
          if (m_pos % S == S-1) m_frame[(m_pos/S)*5 +: 5] = held[(m_pos/S)*5 +: 5];
        end else if (m_pos == 5*S) begin
          m_stable = (m_frame == m_prev) ? ((m_stable + 1 > DB) ? DB : m_stable + 1) : 1;
          m_prev   = m_frame;
          m_emit   = (m_stable >= DB) && (m_frame != m_ks);
        end else begin
          m_i = m_pos - 5*S - 1;
          if (m_frame[m_i] != m_ks[m_i]) begin
            mp_push    = 1'b1;
            mp_ev      = {m_frame[m_i], 5'(m_i)};
            m_ks[m_i]  = m_frame[m_i];
          end
        end
        m_pos++;
        if ((m_pos == 5*S+1 && !m_emit) || m_pos == 5*S+26) m_pos = 0;
      end
      mp_drop = mp_push && (m_q.size() == DEPTH) && !mp_pop;
      if (mp_pop) void'(m_q.pop_front());
      if (mp_push && !mp_drop) m_q.push_back(mp_ev);
      if (mp_drop) m_ovf = 1'b1;
      else if (clr_ovf) m_ovf = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      if (m_load || m_pos >= 5*S) m_eb = 5'h1F;
      else m_eb = ~(5'b00001 << (m_pos / S));
      chk("m_btnx", 32'(btnx), 32'(m_eb));
      chk("m_key_valid", 32'(key_valid), 32'(m_q.size() > 0));
      chk("m_key_code", 32'(key_code), 32'((m_q.size() > 0) ? m_q[0] : 6'h00));
      chk("m_key_state", 32'(key_state), 32'(m_ks));
      chk("m_overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  task automatic wait_valid(input int maxc, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (key_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Returns at the negedge inside the first EMIT cycle: column 4, then two undriven cycles in a row.
  task automatic wait_emit_start(input int maxc, output bit ok);
    int ph;
    ok = 1'b0;
    ph = 0;
    for (int k = 0; k < maxc; k++) begin
      @(negedge clk);
      if (btnx == 5'b01111) ph = 1;
      else if (ph == 1 && btnx == 5'h1F) ph = 2;
      else if (ph == 2 && btnx == 5'h1F) begin
        ok = 1'b1;
        break;
      end else ph = 0;
    end
  endtask

  initial begin
    repeat (30000) @(posedge clk);
    $display("FAIL watchdog: run still active after 30000 cycles, want finish");
    $fatal(1);
  end

  logic [4:0] walk [5];
  logic [5:0] exp5 [8];
  logic [5:0] exp6 [5];
  bit         ok;
  int         nv;

  initial begin
    walk = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
    exp5 = '{6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h00};
    exp6 = '{6'h24, 6'h25, 6'h26, 6'h27, 6'h28};
    rst = 1'b1; key_ready = 1'b0; clr_ovf = 1'b0;
    held = 25'd1 << 7;

    // 1: reset and column walk
    repeat (3) @(negedge clk);
    chk("rst_btnx", 32'(btnx), 32'h1F);
    chk("rst_key_valid", 32'(key_valid), 32'h0);
    chk("rst_key_state", 32'(key_state), 32'h0);
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'h0);
    rst = 1'b0;
    for (int c = 0; c < 5; c++)
      for (int k = 0; k < S; k++) begin
        @(negedge clk);
        chk("walk_btnx", 32'(btnx), 32'(walk[c]));
      end

    // 2: key 7 press, popped once, no repeat
    key_ready = 1'b1;
    wait_valid(300, ok);
    chk("press7_seen", 32'(ok), 32'h1);
    chk("press7_code", 32'(key_code), 32'h27);
    chk("press7_state", 32'(key_state[7]), 32'h1);
    nv = 0;
    repeat (150) begin
      @(negedge clk);
      if (key_valid) nv++;
    end
    chk("press7_no_repeat", 32'(nv), 32'h0);

    // 3: release key 7, then bounce key 12
    held = '0;
    repeat (150) @(negedge clk);
    chk("release7_state", 32'(key_state), 32'h0);
    nv = 0;
    repeat (3) begin
      held[12] = 1'b1;
      repeat (10) begin @(negedge clk); if (key_valid) nv++; end
      held[12] = 1'b0;
      repeat (32) begin @(negedge clk); if (key_valid) nv++; end
    end
    repeat (60) begin @(negedge clk); if (key_valid) nv++; end
    chk("bounce_events", 32'(nv), 32'h0);
    chk("bounce_state", 32'(key_state), 32'h0);

    // 4: keys 3 and 20 together, ordered press then release events
    key_ready = 1'b0;
    held = (25'd1 << 3) | (25'd1 << 20);
    wait_valid(300, ok);
    chk("pair_seen", 32'(ok), 32'h1);
    repeat (30) @(negedge clk);
    chk("pair_head0", 32'(key_code), 32'h23);
    key_ready = 1'b1; @(negedge clk); key_ready = 1'b0;
    chk("pair_head1", 32'(key_code), 32'h34);
    key_ready = 1'b1; @(negedge clk); key_ready = 1'b0;
    chk("pair_empty", 32'(key_valid), 32'h0);
    held = '0;
    wait_valid(300, ok);
    chk("pair_rel_seen", 32'(ok), 32'h1);
    repeat (30) @(negedge clk);
    chk("pair_rel0", 32'(key_code), 32'h03);
    key_ready = 1'b1; @(negedge clk); key_ready = 1'b0;
    chk("pair_rel1", 32'(key_code), 32'h14);
    key_ready = 1'b1; @(negedge clk); key_ready = 1'b0;
    chk("pair_rel_empty", 32'(key_valid), 32'h0);

    // 5: nine presses into an eight-deep FIFO
    held = 25'h1FF;
    repeat (150) @(negedge clk);
    chk("ovf_set", 32'(overflow), 32'h1);
    chk("ovf_state", 32'(key_state[8:0]), 32'h1FF);
    chk("ovf_head", 32'(key_code), 32'h20);
    clr_ovf = 1'b1; @(negedge clk); clr_ovf = 1'b0;
    chk("ovf_clear", 32'(overflow), 32'h0);
    held[0] = 1'b0;
    wait_emit_start(300, ok);
    chk("full_emit_seen", 32'(ok), 32'h1);
    key_ready = 1'b1; @(negedge clk); key_ready = 1'b0;
    repeat (30) @(negedge clk);
    chk("full_pushpop_ovf", 32'(overflow), 32'h0);
    chk("full_pushpop_state", 32'(key_state[8:0]), 32'h1FE);
    for (int i = 0; i < 8; i++) begin
      chk("drain_valid", 32'(key_valid), 32'h1);
      chk("drain_code", 32'(key_code), 32'(exp5[i]));
      key_ready = 1'b1;
      @(negedge clk);
    end
    key_ready = 1'b0;
    chk("drain_empty", 32'(key_valid), 32'h0);

    // 6: reset during EMIT with three events pending
    held = 25'h1F0;
    wait_emit_start(300, ok);
    chk("rst_emit_seen", 32'(ok), 32'h1);
    repeat (4) @(negedge clk);
    chk("pend_valid", 32'(key_valid), 32'h1);
    chk("pend_state", 32'(key_state[8:0]), 32'h1F0);
    rst = 1'b1; @(negedge clk);
    chk("mid_rst_valid", 32'(key_valid), 32'h0);
    chk("mid_rst_state", 32'(key_state), 32'h0);
    chk("mid_rst_btnx", 32'(btnx), 32'h1F);
    rst = 1'b0; @(negedge clk);
    chk("restart_btnx", 32'(btnx), 32'h1E);
    key_ready = 1'b1;
    wait_valid(300, ok);
    chk("rereport_seen", 32'(ok), 32'h1);
    for (int i = 0; i < 5; i++) begin
      chk("rereport_code", 32'(key_code), 32'(exp6[i]));
      @(negedge clk);
    end
    chk("rereport_state", 32'(key_state), 32'h1F0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
